// File: rtl/rng_pkg.sv
// Shared types and constants for the dice-style random roller.
package rng_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned OUT_W  = 4;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 13;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 10;

  typedef enum logic {
    S_IDLE,
    S_ROLL
  } state_e;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] l);
    return l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
  endfunction

endpackage

// File: rtl/rng_roller_if.sv
// Slow-clock/start inputs and roll result outputs of the roller.
interface rng_roller_if;
  import rng_pkg::*;

  logic             i_slow_clk;
  logic             i_start;
  logic [OUT_W-1:0] o_random_out;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_slow_clk,
    output i_start,
    input  o_random_out,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_slow_clk,
    input  i_start,
    output o_random_out,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advancing every clock.
module lfsr16
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= {state_q[LFSR_W-2:0], lfsr_fb(state_q)};
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/rng_roller.sv
// Rolling random value that slows down stage by stage on slow-clock ticks, then freezes.
module rng_roller
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED              = DEFAULT_SEED,
  parameter int unsigned       NUM_STAGES        = 5,
  parameter int unsigned       UPDATES_PER_STAGE = 4
) (
  input logic         i_clk,
  input logic         i_rst_n,
  rng_roller_if.slave bus
);

  localparam int unsigned StageW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned UpdW   = (UPDATES_PER_STAGE > 1) ? $clog2(UPDATES_PER_STAGE) : 1;
  localparam int unsigned TickW  = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;

  state_e            state_q, state_d;
  logic [StageW-1:0] stage_q, stage_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [UpdW-1:0]   upd_cnt_q, upd_cnt_d;
  logic [OUT_W-1:0]  random_q, random_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              slow_d;
  logic              tick;
  logic [TickW:0]    period_last;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_state(lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:OUT_W];

  // Slow clock is sampled as data; only its rising edge matters.
  assign tick        = bus.i_slow_clk & ~slow_d;
  assign period_last = ((TickW+1)'(1) << stage_q) - (TickW+1)'(1);

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    tick_cnt_d = tick_cnt_q;
    upd_cnt_d  = upd_cnt_q;
    random_d   = random_q;
    done_d     = 1'b0;

    // Start takes priority over any tick, including the final one.
    if (bus.i_start) begin
      state_d    = S_ROLL;
      stage_d    = '0;
      tick_cnt_d = '0;
      upd_cnt_d  = '0;
    end else if (state_q == S_ROLL && tick) begin
      if ({1'b0, tick_cnt_q} == period_last) begin
        tick_cnt_d = '0;
        random_d   = lfsr[OUT_W-1:0];
        if (upd_cnt_q == UpdW'(UPDATES_PER_STAGE - 1)) begin
          upd_cnt_d = '0;
          if (stage_q == StageW'(NUM_STAGES - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stage_d = stage_q + StageW'(1);
          end
        end else begin
          upd_cnt_d = upd_cnt_q + UpdW'(1);
        end
      end else begin
        tick_cnt_d = tick_cnt_q + TickW'(1);
      end
    end

    busy_d = (state_d == S_ROLL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      tick_cnt_q <= '0;
      upd_cnt_q  <= '0;
      random_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      slow_d     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      tick_cnt_q <= tick_cnt_d;
      upd_cnt_q  <= upd_cnt_d;
      random_q   <= random_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      slow_d     <= bus.i_slow_clk;
    end
  end

  assign bus.o_random_out = random_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_rng_roller.sv
// Directed bench for rng_roller: reset, full roll, idle ticks, restart, start/final collision, reset.
module tb_rng_roller;

  logic clk;
  logic rst_n;
  logic [15:0] ref_lfsr;
  int vectors;
  int miscompares;
  int upd_ticks [20] = '{1, 2, 3, 4, 6, 8, 10, 12, 16, 20, 24, 28, 36, 44, 52, 60,
                         76, 92, 108, 124};

  rng_roller_if bus ();

  rng_roller dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR running in lockstep with the design's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 16'hACE1;
    else        ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  function automatic bit is_upd(input int idx);
    for (int i = 0; i < 20; i++) if (upd_ticks[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One 8-cycle slow-clock period; the rising edge is the tick.
  task automatic do_tick(input int idx, input bit rolling, input bit with_start);
    logic [3:0] exp_val;
    bit upd;
    bit fin;
    upd     = rolling && !with_start && is_upd(idx);
    fin     = rolling && !with_start && (idx == 124);
    exp_val = upd ? ref_lfsr[3:0] : bus.o_random_out;
    bus.i_slow_clk = 1'b1;
    bus.i_start    = with_start;
    @(negedge clk);
    bus.i_start = 1'b0;
    check($sformatf("rand@%0d", idx), 16'(bus.o_random_out), 16'(exp_val));
    check($sformatf("done@%0d", idx), 16'(bus.o_done), 16'(fin));
    check($sformatf("busy@%0d", idx), 16'(bus.o_busy), 16'((rolling && !fin) || with_start));
    @(negedge clk);
    check($sformatf("done_drop@%0d", idx), 16'(bus.o_done), 16'h0);
    repeat (2) @(negedge clk);
    bus.i_slow_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_pulse();
    logic [3:0] hold;
    hold        = bus.o_random_out;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("start_busy", 16'(bus.o_busy), 16'h1);
    check("start_hold", 16'(bus.o_random_out), 16'(hold));
    check("start_done", 16'(bus.o_done), 16'h0);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.i_slow_clk = 1'b0;
    bus.i_start    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_lfsr", dut.lfsr, 16'hACE1);
    check("rst_rand", 16'(bus.o_random_out), 16'h0);
    check("rst_busy", 16'(bus.o_busy), 16'h0);
    check("rst_done", 16'(bus.o_done), 16'h0);
    @(negedge clk);
    check("lfsr_step", dut.lfsr, 16'h59C3);
    repeat (3) @(negedge clk);

    // Full roll to completion.
    start_pulse();
    for (int t = 1; t <= 124; t++) do_tick(t, 1'b1, 1'b0);

    // Ticks while idle must not disturb the frozen value.
    for (int t = 0; t < 2; t++) do_tick(0, 1'b0, 1'b0);

    // Restart after 10 ticks, then a complete roll from scratch.
    start_pulse();
    for (int t = 1; t <= 10; t++) do_tick(t, 1'b1, 1'b0);
    start_pulse();
    for (int t = 1; t <= 124; t++) do_tick(t, 1'b1, 1'b0);

    // Start coincides with the final tick: no done, new roll begins.
    start_pulse();
    for (int t = 1; t <= 123; t++) do_tick(t, 1'b1, 1'b0);
    do_tick(124, 1'b1, 1'b1);
    do_tick(1, 1'b1, 1'b0);
    do_tick(2, 1'b1, 1'b0);

    // Asynchronous reset mid-roll.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 16'(bus.o_busy), 16'h0);
    check("mid_rst_rand", 16'(bus.o_random_out), 16'h0);
    check("mid_rst_done", 16'(bus.o_done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_tick(0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
